psa_arbiter: RTL and testbench

- Shares one 16-bit parallel sub-word adder (four independent 4-bit lanes, saturating, OR-ed lane error flag) between two requesters: the execute-stage PADDSB path (requester 0) and a debug/checksum engine (requester 1).
- Round-robin arbitration, a result register, and a response handshake, so the adder datapath is instantiated once.
- Sits beside the ALU in execute.

---
 rtl/psa_arb_pkg.sv | 31 +++
 rtl/psa_arbiter_if.sv | 26 ++
 rtl/psa_arbiter_adder.sv | 36 +++
 rtl/psa_arbiter.sv | 124 ++++++++++++
 tb/tb_psa_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/psa_arb_pkg.sv
// Shared types and constants for the psa_arbiter slice.
package psa_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int REQ_EXEC = 0;
    localparam int REQ_DBG  = 1;

    localparam int DATA_W    = 16;
    localparam int LANE_W    = 4;
    localparam int NUM_LANES = DATA_W / LANE_W;

    localparam logic [LANE_W-1:0] LANE_MAX = 4'h7;
    localparam logic [LANE_W-1:0] LANE_MIN = 4'h8;

    // Turns a requester index into its one-hot grant/response vector.
    function automatic logic [1:0] req_onehot(input logic idx);
        logic [1:0] v;
        v = '0;
        if (idx == REQ_DBG[0]) begin
            v[REQ_DBG] = 1'b1;
        end else begin
            v[REQ_EXEC] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/psa_arbiter_if.sv
// Request/response bundle between the two requesters and psa_arbiter.
interface psa_arbiter_if;
    import psa_arb_pkg::*;

    logic [1:0]        req;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [1:0]        gnt;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ack;
    logic [DATA_W-1:0] sum;
    logic              err;

    modport master (
        output req, a0, b0, a1, b1, resp_ack,
        input  gnt, resp_valid, sum, err
    );

    modport slave (
        input  req, a0, b0, a1, b1, resp_ack,
        output gnt, resp_valid, sum, err
    );

endinterface

// File: rtl/psa_arbiter_adder.sv
// 16-bit parallel sub-word adder: four independent signed-saturating 4-bit lanes.
module psa_arbiter_adder
    import psa_arb_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          err
);

    localparam int NL = DW / LANE_W;

    logic [NL-1:0] lane_ovf;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] raw;

        assign la  = a[i*LANE_W +: LANE_W];
        assign lb  = b[i*LANE_W +: LANE_W];
        assign raw = la + lb;

        // Signed overflow: operands share a sign the wrapped result lacks.
        assign lane_ovf[i] = (la[LANE_W-1] == lb[LANE_W-1]) &&
                             (raw[LANE_W-1] != la[LANE_W-1]);

        assign sum[i*LANE_W +: LANE_W] =
            lane_ovf[i] ? (la[LANE_W-1] ? LANE_MIN : LANE_MAX) : raw;
    end

    assign err = |lane_ovf;

endmodule

// File: rtl/psa_arbiter.sv
// Round-robin arbiter sharing one sub-word adder between two requesters.
// Define PSA_ARB_STATS_EN to add saturating grant/error counters.
module psa_arbiter
    import psa_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    psa_arbiter_if.slave  bus
`ifdef PSA_ARB_STATS_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1,
    output logic [15:0]   err_cnt
`endif
);

    if (NUM_REQ != 2) begin : g_bad_num_req
        $error("psa_arbiter: NUM_REQ must be 2");
    end
    if (DW != DATA_W || (DW % LANE_W) != 0) begin : g_bad_dw
        $error("psa_arbiter: DW must be 16");
    end

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              owner;
    logic              accept;
    logic              winner;
    logic              grant_any;
    logic [1:0]        gnt_c;
    logic [1:0]        resp_valid_q;
    logic [DW-1:0]     sum_q;
    logic              err_q;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic [DW-1:0]     add_sum;
    logic              add_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new pair is accepted when idle or when the owner retires its result.
    always_comb begin
        state_nxt = state;
        gnt_c     = '0;
        winner    = prio;
        grant_any = 1'b0;
        accept    = (state == IDLE) || bus.resp_ack[owner];
        if (accept) begin
            if (bus.req != 2'b00) begin
                grant_any = 1'b1;
                winner    = bus.req[prio] ? prio : ~prio;
                gnt_c     = req_onehot(winner);
                state_nxt = RESP;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign op_a = (winner == REQ_DBG[0]) ? bus.a1 : bus.a0;
    assign op_b = (winner == REQ_DBG[0]) ? bus.b1 : bus.b0;

    psa_arbiter_adder #(.DW(DW)) u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum),
        .err (add_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio         <= 1'b0;
            owner        <= 1'b0;
            resp_valid_q <= '0;
            sum_q        <= '0;
            err_q        <= 1'b0;
        end else if (grant_any) begin
            sum_q        <= add_sum;
            err_q        <= add_err;
            owner        <= winner;
            resp_valid_q <= gnt_c;
            prio         <= ~winner;
        end else if (state == RESP && accept) begin
            resp_valid_q <= '0;
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.sum        = sum_q;
    assign bus.err        = err_q;

`ifdef PSA_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (gnt_c[REQ_EXEC] && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (gnt_c[REQ_DBG] && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            // An error event is a freshly registered result with err set.
            if (grant_any && add_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psa_arbiter.sv
// Directed scoreboard bench for psa_arbiter (optionally with PSA_ARB_STATS_EN).
module tb_psa_arbiter;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] sum;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    psa_arbiter_if bus ();

`ifdef PSA_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] err_cnt;
`endif

    psa_arbiter #(.NUM_REQ(2), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef PSA_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .err_cnt    (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference lane adder using integer clamping; returns {err, sum}.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic        e;
        int          x;
        s = '0;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
            if (x > 7) begin
                s[4*i +: 4] = 4'h7;
                e = 1'b1;
            end else if (x < -8) begin
                s[4*i +: 4] = 4'h8;
                e = 1'b1;
            end else begin
                s[4*i +: 4] = x[3:0];
            end
        end
        return {e, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] ack,
                                 input logic [15:0] a0v, input logic [15:0] b0v,
                                 input logic [15:0] a1v, input logic [15:0] b1v);
        bus.req      = r;
        bus.resp_ack = ack;
        bus.a0       = a0v;
        bus.b0       = b0v;
        bus.a1       = a1v;
        bus.b1       = b1v;
    endtask

    // One cycle: check the grant, push the expected result, then check the response.
    task automatic runCycle(input string tag, input logic [1:0] exp_gnt);
        exp_t        e;
        logic [16:0] m;
        #1;
        checkOutput({tag, ".gnt"}, {30'd0, bus.gnt}, {30'd0, exp_gnt});
        if (exp_gnt != 2'b00) begin
            m     = exp_gnt[1] ? model(bus.a1, bus.b1) : model(bus.a0, bus.b0);
            e.gnt = exp_gnt;
            e.sum = m[15:0];
            e.err = m[16];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_gnt != 2'b00) begin
            if (sb.size() == 0) begin
                failures++;
                $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
            end else begin
                e = sb.pop_front();
                checkOutput({tag, ".resp_valid"}, {30'd0, bus.resp_valid}, {30'd0, e.gnt});
                checkOutput({tag, ".sum"}, {16'd0, bus.sum}, {16'd0, e.sum});
                checkOutput({tag, ".err"}, {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    endtask

    initial begin
        logic [1:0]  ack;
        logic [1:0]  expg;
        logic [16:0] held;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        #1;
        checkOutput("reset.gnt", {30'd0, bus.gnt}, 32'd0);
        checkOutput("reset.resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        checkOutput("reset.sum", {16'd0, bus.sum}, 32'd0);
        checkOutput("reset.err", {31'd0, bus.err}, 32'd0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester 0, acked immediately, then back to idle.
        applyStimulus(2'b01, 2'b00, 16'h1234, 16'h1111, 16'h0, 16'h0);
        runCycle("single", 2'b01);
        applyStimulus(2'b00, 2'b01, 16'h1234, 16'h1111, 16'h0, 16'h0);
        runCycle("single_done", 2'b00);
        checkOutput("single_idle.resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        checkOutput("single_idle.sum_hold", {16'd0, bus.sum}, 32'h2345);

        // Saturation on requester 1, positive then negative, back to back.
        applyStimulus(2'b10, 2'b00, 16'h0, 16'h0, 16'h7777, 16'h1111);
        runCycle("sat_pos", 2'b10);
        applyStimulus(2'b10, 2'b10, 16'h0, 16'h0, 16'h8888, 16'hFFFF);
        runCycle("sat_neg", 2'b10);
        applyStimulus(2'b00, 2'b10, 16'h0, 16'h0, 16'h0, 16'h0);
        runCycle("sat_done", 2'b00);

        // Continuous contention with immediate acks alternates grants.
        ack = 2'b00;
        for (int k = 0; k < 4; k++) begin
            expg = (k % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus(2'b11, ack, 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom));
            runCycle($sformatf("contend%0d", k), expg);
            ack = expg;
        end
        applyStimulus(2'b00, ack, 16'h0, 16'h0, 16'h0, 16'h0);
        runCycle("contend_done", 2'b00);

        // Backpressure: owner withholds ack; a non-owner ack bit is ignored.
        applyStimulus(2'b01, 2'b00, 16'h4321, 16'h2222, 16'h0F0F, 16'h0101);
        held = model(16'h4321, 16'h2222);
        runCycle("bp_first", 2'b01);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b10, (k == 2) ? 2'b10 : 2'b00, 16'h4321, 16'h2222, 16'h0F0F, 16'h0101);
            #1;
            checkOutput($sformatf("bp_stall%0d.gnt", k), {30'd0, bus.gnt}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_stall%0d.resp_valid", k), {30'd0, bus.resp_valid}, 32'd1);
            checkOutput($sformatf("bp_stall%0d.sum", k), {16'd0, bus.sum}, {16'd0, held[15:0]});
        end
        applyStimulus(2'b10, 2'b01, 16'h4321, 16'h2222, 16'h0F0F, 16'h0101);
        runCycle("bp_release", 2'b10);
        applyStimulus(2'b00, 2'b10, 16'h0, 16'h0, 16'h0, 16'h0);
        runCycle("bp_done", 2'b00);
        checkOutput("bp_done.resp_valid", {30'd0, bus.resp_valid}, 32'd0);

        // Asynchronous reset between edges while a result is held.
        applyStimulus(2'b01, 2'b00, 16'h0303, 16'h0404, 16'h0, 16'h0);
        runCycle("rst_pre", 2'b01);
        applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_mid.sum", {16'd0, bus.sum}, 32'd0);
        checkOutput("rst_mid.err", {31'd0, bus.err}, 32'd0);
        #2;
        rst = 1'b0;

        // After reset requester 0 has priority; three exec and two debug grants.
        applyStimulus(2'b11, 2'b00, 16'h1234, 16'h1111, 16'h0101, 16'h0202);
        runCycle("post_rst0", 2'b01);
        applyStimulus(2'b11, 2'b01, 16'h1234, 16'h1111, 16'h0101, 16'h0202);
        runCycle("post_rst1", 2'b10);
        applyStimulus(2'b11, 2'b10, 16'h1234, 16'h1111, 16'h0101, 16'h0202);
        runCycle("post_rst2", 2'b01);
        applyStimulus(2'b11, 2'b01, 16'h1234, 16'h1111, 16'h0101, 16'h0202);
        runCycle("post_rst3", 2'b10);
        applyStimulus(2'b01, 2'b10, 16'h7000, 16'h1000, 16'h0, 16'h0);
        runCycle("post_rst4", 2'b01);
        applyStimulus(2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0);
        runCycle("post_rst_done", 2'b00);
        checkOutput("post_rst_done.resp_valid", {30'd0, bus.resp_valid}, 32'd0);

`ifdef PSA_ARB_STATS_EN
        checkOutput("stats.grant_cnt0", {16'd0, grant_cnt0}, 32'd3);
        checkOutput("stats.grant_cnt1", {16'd0, grant_cnt1}, 32'd2);
        checkOutput("stats.err_cnt", {16'd0, err_cnt}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
